ex_mem_stage: RTL and testbench

Execute stage plus EX/MEM pipeline register for the 5-stage MIPS pipeline. It consumes the ID/EX register outputs and resolves data hazards by forwarding from EX/MEM and MEM/WB. It decodes ALUOp/funct, computes the ALU result and destination register, and registers everything for the MEM stage. An optional multi-cycle multiplier stalls the upstream stages while it runs.

---
 rtl/ex_pkg.sv | 75 +++++++
 rtl/ex_mem_stage_if.sv | 47 ++++
 rtl/ex_alu.sv | 24 ++
 rtl/ex_mem_stage.sv | 161 ++++++++++++++++
 tb/tb_ex_mem_stage.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage / EX-MEM register.
// The multiplier-related types are only used when EX_MULT_EN is defined.
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADD2  = 2'b11;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_MULT = 6'h18;

    localparam logic [4:0] MUL_LAST_STEP = 5'd31;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_NOP
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG, FWD_EXMEM, FWD_MEMWB
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MUL_IDLE, MUL_BUSY, MUL_DONE
    } mul_state_e;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        zero;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        mem_to_reg;
    } ex_mem_t;

    // Unknown funct codes (including MULT when the multiplier is absent) map to NOP.
    function automatic alu_op_e decode_alu(input logic [1:0] aluop, input logic [5:0] funct);
        alu_op_e op;
        op = ALU_NOP;
        case (aluop)
            ALUOP_ADD, ALUOP_ADD2: op = ALU_ADD;
            ALUOP_SUB:             op = ALU_SUB;
            default: begin
                case (funct)
                    FUNCT_ADD: op = ALU_ADD;
                    FUNCT_SUB: op = ALU_SUB;
                    FUNCT_AND: op = ALU_AND;
                    FUNCT_OR:  op = ALU_OR;
                    FUNCT_SLT: op = ALU_SLT;
                    default:   op = ALU_NOP;
                endcase
            end
        endcase
        return op;
    endfunction

    // EX/MEM wins over MEM/WB; register $0 is never forwarded.
    function automatic fwd_sel_e fwd_select(input logic [4:0] src, input ex_mem_t exm,
                                            input logic wb_we, input logic [4:0] wb_rd);
        fwd_sel_e sel;
        sel = FWD_REG;
        if (exm.reg_write && exm.rd != 5'd0 && exm.rd == src)
            sel = FWD_EXMEM;
        else if (wb_we && wb_rd != 5'd0 && wb_rd == src)
            sel = FWD_MEMWB;
        return sel;
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX inputs, MEM/WB forwarding source and EX/MEM outputs of the execute stage.
// master = upstream/pipeline side, slave = the execute stage itself.
interface ex_mem_stage_if;
    logic [31:0] ID_EX_RsData;
    logic [31:0] ID_EX_RtData;
    logic [31:0] ID_EX_SignExtImm;
    logic [4:0]  ID_EX_Rs;
    logic [4:0]  ID_EX_Rt;
    logic [4:0]  ID_EX_Rd;
    logic [1:0]  ID_EX_ALUOp;
    logic        ID_EX_RegWrite;
    logic        ID_EX_MemWrite;
    logic        ID_EX_MemRead;
    logic        ID_EX_ALUSrc;
    logic        ID_EX_MemtoReg;
    logic        ID_EX_RegDst;

    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_Rd;
    logic [31:0] MEM_WB_WriteData;

    logic [31:0] EX_MEM_ALUResult;
    logic [31:0] EX_MEM_WriteData;
    logic [4:0]  EX_MEM_Rd;
    logic        EX_MEM_Zero;
    logic        EX_MEM_RegWrite;
    logic        EX_MEM_MemWrite;
    logic        EX_MEM_MemRead;
    logic        EX_MEM_MemtoReg;
    logic        EX_Busy;

    modport master (
        output ID_EX_RsData, ID_EX_RtData, ID_EX_SignExtImm, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd,
               ID_EX_ALUOp, ID_EX_RegWrite, ID_EX_MemWrite, ID_EX_MemRead, ID_EX_ALUSrc,
               ID_EX_MemtoReg, ID_EX_RegDst, MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_WriteData,
        input  EX_MEM_ALUResult, EX_MEM_WriteData, EX_MEM_Rd, EX_MEM_Zero, EX_MEM_RegWrite,
               EX_MEM_MemWrite, EX_MEM_MemRead, EX_MEM_MemtoReg, EX_Busy
    );

    modport slave (
        input  ID_EX_RsData, ID_EX_RtData, ID_EX_SignExtImm, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd,
               ID_EX_ALUOp, ID_EX_RegWrite, ID_EX_MemWrite, ID_EX_MemRead, ID_EX_ALUSrc,
               ID_EX_MemtoReg, ID_EX_RegDst, MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_WriteData,
        output EX_MEM_ALUResult, EX_MEM_WriteData, EX_MEM_Rd, EX_MEM_Zero, EX_MEM_RegWrite,
               EX_MEM_MemWrite, EX_MEM_MemRead, EX_MEM_MemtoReg, EX_Busy
    );
endinterface

// File: rtl/ex_alu.sv
// Combinational 32-bit ALU: add/sub/and/or/signed slt, NOP yields 0.
module ex_alu
    import ex_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/ex_mem_stage.sv
// MIPS execute stage with forwarding and the EX/MEM pipeline register.
// Define EX_MULT_EN to add the 32-step shift-add multiplier (funct 0x18) and EX_Busy stall.
module ex_mem_stage
    import ex_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    ex_mem_stage_if.slave bus
);
    ex_mem_t     ex_mem_q, ex_mem_d;
    fwd_sel_e    sel_a, sel_b;
    logic [31:0] fwd_a, fwd_b;
    alu_op_e     alu_op;
    logic [31:0] alu_a, alu_b, alu_res;
    logic        alu_zero;
    logic        id_bubble;
    logic        hold_bubble;

`ifdef EX_MULT_EN
    mul_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
    logic        is_mult, busy, use_prod;
`endif

    assign sel_a = fwd_select(bus.ID_EX_Rs, ex_mem_q, bus.MEM_WB_RegWrite, bus.MEM_WB_Rd);
    assign sel_b = fwd_select(bus.ID_EX_Rt, ex_mem_q, bus.MEM_WB_RegWrite, bus.MEM_WB_Rd);

    always_comb begin
        case (sel_a)
            FWD_EXMEM: fwd_a = ex_mem_q.result;
            FWD_MEMWB: fwd_a = bus.MEM_WB_WriteData;
            default:   fwd_a = bus.ID_EX_RsData;
        endcase
        case (sel_b)
            FWD_EXMEM: fwd_b = ex_mem_q.result;
            FWD_MEMWB: fwd_b = bus.MEM_WB_WriteData;
            default:   fwd_b = bus.ID_EX_RtData;
        endcase
    end

    // A fully zero ID/EX word is a bubble; only Zero needs masking to keep the entry all-zero.
    assign id_bubble = ~|{bus.ID_EX_RsData, bus.ID_EX_RtData, bus.ID_EX_SignExtImm,
                          bus.ID_EX_Rs, bus.ID_EX_Rt, bus.ID_EX_Rd, bus.ID_EX_ALUOp,
                          bus.ID_EX_RegWrite, bus.ID_EX_MemWrite, bus.ID_EX_MemRead,
                          bus.ID_EX_ALUSrc, bus.ID_EX_MemtoReg, bus.ID_EX_RegDst};

`ifdef EX_MULT_EN
    assign is_mult = rst_n && bus.ID_EX_ALUOp == ALUOP_FUNCT
                     && bus.ID_EX_SignExtImm[5:0] == FUNCT_MULT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        busy     = 1'b0;
        use_prod = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (is_mult) begin
                    state_d  = MUL_BUSY;
                    cnt_d    = '0;
                    mcand_d  = fwd_a;
                    mplier_d = fwd_b;
                    prod_d   = '0;
                    busy     = 1'b1;
                end
            end
            MUL_BUSY: begin
                busy     = 1'b1;
                prod_d   = prod_q + (mplier_q[0] ? mcand_q : 32'd0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == MUL_LAST_STEP)
                    state_d = MUL_DONE;
            end
            MUL_DONE: begin
                use_prod = 1'b1;
                state_d  = MUL_IDLE;
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    assign hold_bubble = busy;
    assign bus.EX_Busy = busy;
`else
    assign hold_bubble = 1'b0;
    assign bus.EX_Busy = 1'b0;
`endif

    // On DONE the product is passed through the ALU as prod+0 so Zero comes out for free.
    always_comb begin
        alu_op = decode_alu(bus.ID_EX_ALUOp, bus.ID_EX_SignExtImm[5:0]);
        alu_a  = fwd_a;
        alu_b  = bus.ID_EX_ALUSrc ? bus.ID_EX_SignExtImm : fwd_b;
`ifdef EX_MULT_EN
        if (use_prod) begin
            alu_op = ALU_ADD;
            alu_a  = prod_q;
            alu_b  = '0;
        end
`endif
    end

    ex_alu u_alu (
        .op     (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_res),
        .zero   (alu_zero)
    );

    always_comb begin
        ex_mem_d.result     = alu_res;
        ex_mem_d.wdata      = fwd_b;
        ex_mem_d.rd         = bus.ID_EX_RegDst ? bus.ID_EX_Rd : bus.ID_EX_Rt;
        ex_mem_d.zero       = alu_zero & ~id_bubble;
        ex_mem_d.reg_write  = bus.ID_EX_RegWrite;
        ex_mem_d.mem_write  = bus.ID_EX_MemWrite;
        ex_mem_d.mem_read   = bus.ID_EX_MemRead;
        ex_mem_d.mem_to_reg = bus.ID_EX_MemtoReg;
        if (hold_bubble)
            ex_mem_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ex_mem_q <= '0;
        else
            ex_mem_q <= ex_mem_d;
    end

    assign bus.EX_MEM_ALUResult = ex_mem_q.result;
    assign bus.EX_MEM_WriteData = ex_mem_q.wdata;
    assign bus.EX_MEM_Rd        = ex_mem_q.rd;
    assign bus.EX_MEM_Zero      = ex_mem_q.zero;
    assign bus.EX_MEM_RegWrite  = ex_mem_q.reg_write;
    assign bus.EX_MEM_MemWrite  = ex_mem_q.mem_write;
    assign bus.EX_MEM_MemRead   = ex_mem_q.mem_read;
    assign bus.EX_MEM_MemtoReg  = ex_mem_q.mem_to_reg;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized + directed bench for ex_mem_stage against a behavioural EX/MEM model.
// Multiplier checks are compiled in when EX_MULT_EN is defined.
module tb_ex_mem_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_mem_stage_if bus();
    ex_mem_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Model of what the EX/MEM register should hold.
    logic [31:0] m_res, m_wd;
    logic [4:0]  m_rd;
    logic        m_zero, m_rw, m_mw, m_mr, m_m2r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
        if (m_rw && r != 0 && m_rd == r) return m_res;
        if (bus.MEM_WB_RegWrite && r != 0 && bus.MEM_WB_Rd == r) return bus.MEM_WB_WriteData;
        return d;
    endfunction

    function automatic logic [31:0] alu(input logic [1:0] op, input logic [5:0] fn,
                                        input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b00 || op == 2'b11) return a + b;
        if (op == 2'b01) return a - b;
        case (fn)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic clr_in();
        bus.ID_EX_RsData = 0; bus.ID_EX_RtData = 0; bus.ID_EX_SignExtImm = 0;
        bus.ID_EX_Rs = 0; bus.ID_EX_Rt = 0; bus.ID_EX_Rd = 0; bus.ID_EX_ALUOp = 0;
        bus.ID_EX_RegWrite = 0; bus.ID_EX_MemWrite = 0; bus.ID_EX_MemRead = 0;
        bus.ID_EX_ALUSrc = 0; bus.ID_EX_MemtoReg = 0; bus.ID_EX_RegDst = 0;
        bus.MEM_WB_RegWrite = 0; bus.MEM_WB_Rd = 0; bus.MEM_WB_WriteData = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".res"},  bus.EX_MEM_ALUResult, m_res);
        chk({tag, ".wd"},   bus.EX_MEM_WriteData, m_wd);
        chk({tag, ".rd"},   32'(bus.EX_MEM_Rd), 32'(m_rd));
        chk({tag, ".zero"}, 32'(bus.EX_MEM_Zero), 32'(m_zero));
        chk({tag, ".ctl"},  32'({bus.EX_MEM_RegWrite, bus.EX_MEM_MemWrite, bus.EX_MEM_MemRead,
                                 bus.EX_MEM_MemtoReg}), 32'({m_rw, m_mw, m_mr, m_m2r}));
        chk({tag, ".busy"}, 32'(bus.EX_Busy), 32'd0);
    endtask

    // Predict the entry for the instruction currently presented, clock it, compare.
    task automatic step(input string tag);
        logic [31:0] a, wd, b, r;
        logic [4:0]  rd;
        logic        bub;
        a   = fwd(bus.ID_EX_Rs, bus.ID_EX_RsData);
        wd  = fwd(bus.ID_EX_Rt, bus.ID_EX_RtData);
        b   = bus.ID_EX_ALUSrc ? bus.ID_EX_SignExtImm : wd;
        r   = alu(bus.ID_EX_ALUOp, bus.ID_EX_SignExtImm[5:0], a, b);
        rd  = bus.ID_EX_RegDst ? bus.ID_EX_Rd : bus.ID_EX_Rt;
        bub = (bus.ID_EX_RsData == 0 && bus.ID_EX_RtData == 0 && bus.ID_EX_SignExtImm == 0 &&
               bus.ID_EX_Rs == 0 && bus.ID_EX_Rt == 0 && bus.ID_EX_Rd == 0 &&
               bus.ID_EX_ALUOp == 0 && !bus.ID_EX_RegWrite && !bus.ID_EX_MemWrite &&
               !bus.ID_EX_MemRead && !bus.ID_EX_ALUSrc && !bus.ID_EX_MemtoReg &&
               !bus.ID_EX_RegDst);
        @(posedge clk); #1;
        m_res = r; m_wd = wd; m_rd = rd; m_zero = (r == 0) && !bub;
        m_rw = bus.ID_EX_RegWrite; m_mw = bus.ID_EX_MemWrite;
        m_mr = bus.ID_EX_MemRead;  m_m2r = bus.ID_EX_MemtoReg;
        check_all(tag);
    endtask

    task automatic model_clear();
        m_res = 0; m_wd = 0; m_rd = 0; m_zero = 0; m_rw = 0; m_mw = 0; m_mr = 0; m_m2r = 0;
    endtask

    task automatic rand_instr();
        logic [31:0] t;
        logic [5:0]  fn;
        case ($urandom_range(0, 7))
            0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
            4: fn = 6'h2A; 5: fn = 6'h3F; 6: fn = 6'h18;
            default: fn = 6'($urandom_range(0, 63));
        endcase
`ifdef EX_MULT_EN
        if (fn == 6'h18) fn = 6'h21;
`endif
        t = $urandom; t[5:0] = fn;
        bus.ID_EX_SignExtImm = t;
        bus.ID_EX_RsData = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        bus.ID_EX_RtData = ($urandom_range(0, 3) == 0) ? bus.ID_EX_RsData : $urandom;
        bus.ID_EX_Rs = 5'($urandom_range(0, 7));
        bus.ID_EX_Rt = 5'($urandom_range(0, 7));
        bus.ID_EX_Rd = 5'($urandom_range(0, 7));
        bus.ID_EX_ALUOp    = 2'($urandom_range(0, 3));
        bus.ID_EX_RegWrite = 1'($urandom_range(0, 1));
        bus.ID_EX_MemWrite = 1'($urandom_range(0, 1));
        bus.ID_EX_MemRead  = 1'($urandom_range(0, 1));
        bus.ID_EX_ALUSrc   = 1'($urandom_range(0, 1));
        bus.ID_EX_MemtoReg = 1'($urandom_range(0, 1));
        bus.ID_EX_RegDst   = 1'($urandom_range(0, 1));
        bus.MEM_WB_RegWrite  = 1'($urandom_range(0, 1));
        bus.MEM_WB_Rd        = 5'($urandom_range(0, 7));
        bus.MEM_WB_WriteData = $urandom;
    endtask

`ifdef EX_MULT_EN
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b);
        int n;
        clr_in(); step({tag, ".pre"});
        bus.ID_EX_Rs = 5'd1; bus.ID_EX_RsData = a;
        bus.ID_EX_Rt = 5'd2; bus.ID_EX_RtData = b;
        bus.ID_EX_Rd = 5'd9; bus.ID_EX_RegDst = 1; bus.ID_EX_RegWrite = 1;
        bus.ID_EX_ALUOp = 2'b10; bus.ID_EX_SignExtImm = 32'h18;
        #1;
        n = 0;
        while (bus.EX_Busy && n < 100) begin
            @(posedge clk); #1;
            n++;
            chk({tag, ".hold"}, 32'(bus.EX_MEM_RegWrite), 32'd0);
        end
        chk({tag, ".busy_cycles"}, n, 33);
        @(posedge clk); #1;
        chk({tag, ".prod"}, bus.EX_MEM_ALUResult, a * b);
        chk({tag, ".rd"},   32'(bus.EX_MEM_Rd), 32'd9);
        chk({tag, ".rw"},   32'(bus.EX_MEM_RegWrite), 32'd1);
        chk({tag, ".zero"}, 32'(bus.EX_MEM_Zero), 32'(a * b == 0));
        clr_in();
        m_res = a * b; m_wd = b; m_rd = 5'd9; m_zero = (a * b == 0);
        m_rw = 1; m_mw = 0; m_mr = 0; m_m2r = 0;
        step({tag, ".post"});
    endtask
`endif

    initial begin
        // Reset with nonzero inputs (a multiply encoding) applied.
        rst_n = 0;
        clr_in();
        bus.ID_EX_RsData = 32'h1234; bus.ID_EX_RtData = 32'h5678; bus.ID_EX_Rs = 1;
        bus.ID_EX_Rt = 2; bus.ID_EX_Rd = 3; bus.ID_EX_ALUOp = 2'b10;
        bus.ID_EX_SignExtImm = 32'h18; bus.ID_EX_RegWrite = 1; bus.ID_EX_MemWrite = 1;
        bus.ID_EX_RegDst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        check_all("reset");

        clr_in(); rst_n = 1;
        step("bubble");

        // add $3,$1,$2 then sub $4,$3,$1 with stale Rs data.
        clr_in();
        bus.ID_EX_Rs = 1; bus.ID_EX_Rt = 2; bus.ID_EX_Rd = 3; bus.ID_EX_RsData = 10;
        bus.ID_EX_RtData = 5; bus.ID_EX_ALUOp = 2'b10; bus.ID_EX_SignExtImm = 32'h20;
        bus.ID_EX_RegDst = 1; bus.ID_EX_RegWrite = 1;
        step("add");
        chk("add.val", bus.EX_MEM_ALUResult, 32'd15);
        bus.ID_EX_Rs = 3; bus.ID_EX_Rt = 1; bus.ID_EX_Rd = 4; bus.ID_EX_RsData = 0;
        bus.ID_EX_RtData = 10; bus.ID_EX_SignExtImm = 32'h22;
        step("sub_fwd");
        chk("sub_fwd.val", bus.EX_MEM_ALUResult, 32'd5);
        chk("sub_fwd.rd", 32'(bus.EX_MEM_Rd), 32'd4);

        // Priority: EX/MEM beats MEM/WB for reg 7.
        clr_in();
        bus.ID_EX_Rt = 7; bus.ID_EX_RegWrite = 1; bus.ID_EX_ALUSrc = 1; bus.ID_EX_RsData = 32'h111;
        step("prio.setup");
        clr_in();
        bus.MEM_WB_RegWrite = 1; bus.MEM_WB_Rd = 7; bus.MEM_WB_WriteData = 32'h222;
        bus.ID_EX_Rs = 7; bus.ID_EX_RsData = 32'h333; bus.ID_EX_ALUSrc = 1; bus.ID_EX_Rt = 8;
        step("prio");
        chk("prio.val", bus.EX_MEM_ALUResult, 32'h111);

        // Register $0 is never forwarded.
        clr_in();
        bus.ID_EX_RegWrite = 1; bus.ID_EX_ALUSrc = 1; bus.ID_EX_Rs = 9; bus.ID_EX_RsData = 32'h444;
        step("r0.setup");
        clr_in();
        bus.MEM_WB_RegWrite = 1; bus.MEM_WB_WriteData = 32'h222;
        bus.ID_EX_RsData = 32'h333; bus.ID_EX_ALUSrc = 1;
        step("r0");
        chk("r0.val", bus.EX_MEM_ALUResult, 32'h333);

        // sw with Rt forwarded from MEM/WB.
        clr_in(); step("sw.pre");
        bus.ID_EX_Rs = 5; bus.ID_EX_RsData = 100; bus.ID_EX_Rt = 6;
        bus.MEM_WB_RegWrite = 1; bus.MEM_WB_Rd = 6; bus.MEM_WB_WriteData = 32'hDEAD;
        bus.ID_EX_ALUSrc = 1; bus.ID_EX_SignExtImm = 32'hFFFF_FFFC; bus.ID_EX_MemWrite = 1;
        step("sw");
        chk("sw.addr", bus.EX_MEM_ALUResult, 32'd96);
        chk("sw.wd", bus.EX_MEM_WriteData, 32'hDEAD);
        chk("sw.mw", 32'(bus.EX_MEM_MemWrite), 32'd1);

        // ALU edge cases.
        clr_in();
        bus.ID_EX_Rs = 1; bus.ID_EX_Rt = 2; bus.ID_EX_Rd = 3; bus.ID_EX_RegDst = 1;
        bus.ID_EX_RegWrite = 1; bus.ID_EX_ALUOp = 2'b10; bus.ID_EX_SignExtImm = 32'h2A;
        bus.ID_EX_RsData = 32'hFFFF_FFFF; bus.ID_EX_RtData = 1;
        step("slt");
        chk("slt.val", bus.EX_MEM_ALUResult, 32'd1);
        clr_in();
        bus.ID_EX_Rs = 1; bus.ID_EX_Rt = 2; bus.ID_EX_ALUOp = 2'b01;
        bus.ID_EX_RsData = 32'h55; bus.ID_EX_RtData = 32'h55;
        step("beq");
        chk("beq.zero", 32'(bus.EX_MEM_Zero), 32'd1);
        clr_in();
        bus.ID_EX_Rs = 1; bus.ID_EX_Rt = 2; bus.ID_EX_ALUOp = 2'b10;
        bus.ID_EX_SignExtImm = 32'h3F; bus.ID_EX_RsData = 7; bus.ID_EX_RtData = 9;
        step("funct3f");
        chk("funct3f.val", bus.EX_MEM_ALUResult, 32'd0);

`ifndef EX_MULT_EN
        clr_in();
        bus.ID_EX_Rs = 1; bus.ID_EX_Rt = 2; bus.ID_EX_ALUOp = 2'b10;
        bus.ID_EX_SignExtImm = 32'h18; bus.ID_EX_RsData = 7; bus.ID_EX_RtData = 9;
        #1;
        chk("mult_off.busy", 32'(bus.EX_Busy), 32'd0);
        step("mult_off");
        chk("mult_off.val", bus.EX_MEM_ALUResult, 32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) clr_in();
            else rand_instr();
            step("rand");
        end

`ifdef EX_MULT_EN
        run_mult("mul", 32'hFFFF_FFFF, 32'd3);
        run_mult("mul_rand", $urandom, $urandom);

        // Reset at BUSY cycle 10 aborts the multiply.
        clr_in(); step("abort.pre");
        bus.ID_EX_Rs = 1; bus.ID_EX_RsData = 32'd1000; bus.ID_EX_Rt = 2; bus.ID_EX_RtData = 32'd7;
        bus.ID_EX_Rd = 9; bus.ID_EX_RegDst = 1; bus.ID_EX_RegWrite = 1;
        bus.ID_EX_ALUOp = 2'b10; bus.ID_EX_SignExtImm = 32'h18;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        chk("abort.busy_before", 32'(bus.EX_Busy), 32'd1);
        rst_n = 0; clr_in();
        @(posedge clk); #1;
        chk("abort.busy", 32'(bus.EX_Busy), 32'd0);
        chk("abort.rw", 32'(bus.EX_MEM_RegWrite), 32'd0);
        rst_n = 1;
        repeat (40) @(posedge clk);
        #1;
        chk("abort.late_rw", 32'(bus.EX_MEM_RegWrite), 32'd0);
        chk("abort.late_res", bus.EX_MEM_ALUResult, 32'd0);
        model_clear();
        bus.ID_EX_RsData = 32'd20; bus.ID_EX_RtData = 32'd22; bus.ID_EX_ALUOp = 2'b00;
        bus.ID_EX_RegWrite = 1; bus.ID_EX_Rt = 4;
        step("abort.idle");
        chk("abort.idle.val", bus.EX_MEM_ALUResult, 32'd42);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
